counter_seq_ctrl: RTL and testbench

Command-driven sequencer for the design's up/down counter datapath. It accepts LOAD/RUN/STOP/CLEAR commands over a valid/ready handshake and drives the counter's load, enable and direction strobes. It watches the counter value for a terminal count and either stops (one-shot) or reloads (wrap). It sits between the pin-decode logic of the top-level wrapper and the counter register.

---
 rtl/counter_seq_pkg.sv | 29 ++
 rtl/counter_seq_prescaler.sv | 33 +++
 rtl/counter_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: controller states,
// command op codes and register reset values.
// Optional build macro used by the controller: COUNTER_SEQ_PRESCALE_EN.
package counter_seq_pkg;

    // Controller state; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        RUN     = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Command op codes carried on cmd_op.
    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Reset values of the single-bit run settings (count up, one-shot).
    localparam logic RST_DIR  = 1'b1;
    localparam logic RST_WRAP = 1'b0;

    // STOP only acts while counting; in any other state it is a no-op.
    function automatic state_t stop_next(input state_t cur);
        return (cur == RUN) ? HOLD : cur;
    endfunction

endpackage

// File: rtl/counter_seq_prescaler.sv
// Tick generator for the counter sequencer. The tick fires once every
// div+1 cycles (div = 0 gives a tick every cycle). clear restarts the
// division so the first tick after RUN entry lands div+1 cycles later.
// Only built when COUNTER_SEQ_PRESCALE_EN is defined.
module counter_seq_prescaler #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] cnt_q;

    // A tick is issued when the phase counter reaches the divide ratio.
    // If div is lowered below the current phase, the counter wraps through
    // 2^W before the next tick; that one stretched period is tolerated.
    assign tick = (cnt_q == div);

    // Phase counter: restart on clear or after each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for the up/down counter datapath.
// Accepts STOP/LOAD/RUN/CLEAR commands, drives the counter load/enable/
// direction strobes and detects the terminal count (one-shot or wrap).
// Optional build macro: COUNTER_SEQ_PRESCALE_EN adds prescale_div and a
// tick divider that slows counting and hit evaluation in RUN.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is low only in LOADING; the source must
// hold cmd_valid and the command fields stable until the transfer.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    input  logic                  cmd_dir,
    input  logic                  cmd_wrap,
`ifdef COUNTER_SEQ_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_div,
`endif
    input  logic [WIDTH-1:0]      cnt_value,
    output logic                  cnt_load,
    output logic [WIDTH-1:0]      cnt_load_val,
    output logic                  cnt_en,
    output logic                  cnt_up,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_o
);

    // Reject configurations that leave a datapath without bits.
    if (WIDTH < 1 || PRESCALE_W < 1) begin : g_bad_params
        $error("counter_seq_ctrl: WIDTH and PRESCALE_W must be at least 1");
    end

    state_t           state;
    logic [WIDTH-1:0] start_reg;
    logic [WIDTH-1:0] limit_reg;
    logic             dir_reg;
    logic             wrap_reg;
    logic             done_reg;

    logic             cmd_acc;
    logic             tick;
    logic             hit_eq;
    logic             hit;

    assign cmd_ready = (state != LOADING);
    assign cmd_acc   = cmd_valid & cmd_ready;

`ifdef COUNTER_SEQ_PRESCALE_EN
    logic run_entry;

    // The divider restarts only when RUN is entered from another state;
    // a RUN command while already running keeps the current phase.
    assign run_entry = cmd_acc & (cmd_op == OP_RUN) & (state != RUN);

    counter_seq_prescaler #(
        .W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (run_entry),
        .div   (prescale_div),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Terminal count: only meaningful while running and on a tick.
    assign hit_eq = (cnt_value == limit_reg);
    assign hit    = (state == RUN) & tick & hit_eq;

    // Sequencer FSM plus command registers and the registered done pulse.
    // An accepted command always decides the next state, which is how a
    // command arriving on a one-shot hit cycle overrides the return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_reg <= '0;
            limit_reg <= '0;
            dir_reg   <= RST_DIR;
            wrap_reg  <= RST_WRAP;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= hit;
            if (cmd_acc) begin
                case (cmd_op)
                    OP_STOP: begin
                        state <= stop_next(state);
                    end
                    OP_LOAD: begin
                        start_reg <= cmd_data;
                        state     <= LOADING;
                    end
                    OP_RUN: begin
                        limit_reg <= cmd_data;
                        dir_reg   <= cmd_dir;
                        wrap_reg  <= cmd_wrap;
                        state     <= RUN;
                    end
                    OP_CLEAR: begin
                        start_reg <= '0;
                        limit_reg <= '0;
                        state     <= LOADING;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end else begin
                case (state)
                    LOADING: state <= IDLE;
                    RUN: begin
                        if (hit && !wrap_reg) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    // Strobes decoded from registered state plus the live hit. LOADING
    // always loads start_reg (zero after CLEAR); a wrap hit reloads it too.
    assign cnt_load     = (state == LOADING) | (hit & wrap_reg);
    assign cnt_load_val = start_reg;
    assign cnt_en       = (state == RUN) & tick & ~hit_eq;
    assign cnt_up       = dir_reg;
    assign busy         = (state == RUN);
    assign done         = done_reg;
    assign state_o      = state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl (default build, prescaler absent).
// A small counter register stands in for the datapath; every check is
// taken at the falling clock edge against hand-computed values.
module tb_counter_seq_ctrl;

  localparam logic [1:0] T_STOP  = 2'b00;
  localparam logic [1:0] T_LOAD  = 2'b01;
  localparam logic [1:0] T_RUN   = 2'b10;
  localparam logic [1:0] T_CLEAR = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_dir = 1'b0;
  logic       cmd_wrap = 1'b0;
  logic [7:0] dp_count;
  logic       cnt_load;
  logic [7:0] cnt_load_val;
  logic       cnt_en;
  logic       cnt_up;
  logic       busy;
  logic       done;
  logic [1:0] state_o;

  int n_vec = 0;
  int n_err = 0;
  int waits;
  int en_c, ld_c, dn_c, bz_c;

  // clock / reset
  always #5 clk = ~clk;

  counter_seq_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_dir      (cmd_dir),
    .cmd_wrap     (cmd_wrap),
    .cnt_value    (dp_count),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_en       (cnt_en),
    .cnt_up       (cnt_up),
    .busy         (busy),
    .done         (done),
    .state_o      (state_o)
  );

  // Counter datapath stand-in: load has priority over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_count <= 8'd0;
    else if (cnt_load) dp_count <= cnt_load_val;
    else if (cnt_en) dp_count <= cnt_up ? dp_count + 8'd1 : dp_count - 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command at a falling edge and hold it until it transfers.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] data,
                          input logic dir, input logic wrap, output int n_wait);
    logic accepted;
    accepted = 1'b0;
    n_wait = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    cmd_dir = dir;
    cmd_wrap = wrap;
    for (int i = 0; i < 10 && !accepted; i++) begin
      accepted = cmd_ready;
      @(negedge clk);
      n_wait++;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(accepted), 32'd1);
  endtask

  // Sample n falling edges starting at the current one and tally strobes.
  task automatic monitor(input int n, output int en_n, output int ld_n,
                         output int dn_n, output int bz_n);
    en_n = 0; ld_n = 0; dn_n = 0; bz_n = 0;
    for (int i = 0; i < n; i++) begin
      en_n += int'(cnt_en);
      ld_n += int'(cnt_load);
      dn_n += int'(done);
      bz_n += int'(busy);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_up", 32'(cnt_up), 32'd1);
    check("rst_en", 32'(cnt_en), 32'd0);
    check("rst_load", 32'(cnt_load), 32'd0);
    check("rst_load_val", 32'(cnt_load_val), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD 5, RUN to 9 up one-shot
    send_cmd(T_LOAD, 8'd5, 1'b0, 1'b0, waits);
    check("ld5_state", 32'(state_o), 32'd1);
    check("ld5_load", 32'(cnt_load), 32'd1);
    check("ld5_val", 32'(cnt_load_val), 32'd5);
    check("ld5_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("ld5_idle", 32'(state_o), 32'd0);
    check("ld5_count", 32'(dp_count), 32'd5);
    send_cmd(T_RUN, 8'd9, 1'b1, 1'b0, waits);
    check("run9_busy", 32'(busy), 32'd1);
    check("run9_up", 32'(cnt_up), 32'd1);
    monitor(8, en_c, ld_c, dn_c, bz_c);
    check("run9_en_cycles", 32'(en_c), 32'd4);
    check("run9_done_pulses", 32'(dn_c), 32'd1);
    check("run9_loads", 32'(ld_c), 32'd0);
    check("run9_end_state", 32'(state_o), 32'd0);
    check("run9_rest", 32'(dp_count), 32'd9);

    // LOAD 3, RUN while LOADING (waits), down to 0 with wrap
    send_cmd(T_LOAD, 8'd3, 1'b0, 1'b0, waits);
    check("ld3_val", 32'(cnt_load_val), 32'd3);
    check("ld3_ready", 32'(cmd_ready), 32'd0);
    send_cmd(T_RUN, 8'd0, 1'b0, 1'b1, waits);
    check("run_during_loading_waits", 32'(waits), 32'd2);
    check("wrap_state", 32'(state_o), 32'd2);
    check("wrap_start", 32'(dp_count), 32'd3);
    check("wrap_dir", 32'(cnt_up), 32'd0);
    monitor(9, en_c, ld_c, dn_c, bz_c);
    check("wrap_en_cycles", 32'(en_c), 32'd7);
    check("wrap_reloads", 32'(ld_c), 32'd2);
    check("wrap_done_pulses", 32'(dn_c), 32'd2);
    check("wrap_busy_cycles", 32'(bz_c), 32'd9);
    check("wrap_count", 32'(dp_count), 32'd2);

    // STOP -> HOLD, value frozen
    send_cmd(T_STOP, 8'd0, 1'b0, 1'b0, waits);
    check("hold_state", 32'(state_o), 32'd3);
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_count", 32'(dp_count), 32'd1);
    monitor(3, en_c, ld_c, dn_c, bz_c);
    check("hold_en", 32'(en_c), 32'd0);
    check("hold_load", 32'(ld_c), 32'd0);
    check("hold_frozen", 32'(dp_count), 32'd1);

    // RUN from HOLD resumes without reload (one-shot to 0)
    send_cmd(T_RUN, 8'd0, 1'b0, 1'b0, waits);
    monitor(3, en_c, ld_c, dn_c, bz_c);
    check("resume_en", 32'(en_c), 32'd1);
    check("resume_load", 32'(ld_c), 32'd0);
    check("resume_done", 32'(dn_c), 32'd1);
    check("resume_state", 32'(state_o), 32'd0);
    check("resume_count", 32'(dp_count), 32'd0);

    // RUN with limit equal to current value
    send_cmd(T_LOAD, 8'd7, 1'b0, 1'b0, waits);
    @(negedge clk);
    check("eq_count", 32'(dp_count), 32'd7);
    send_cmd(T_RUN, 8'd7, 1'b1, 1'b0, waits);
    check("eq_first_en", 32'(cnt_en), 32'd0);
    check("eq_first_state", 32'(state_o), 32'd2);
    check("eq_first_done", 32'(done), 32'd0);
    monitor(2, en_c, ld_c, dn_c, bz_c);
    check("eq_en", 32'(en_c), 32'd0);
    check("eq_done", 32'(dn_c), 32'd1);
    check("eq_state", 32'(state_o), 32'd0);
    check("eq_rest", 32'(dp_count), 32'd7);

    // Command on the same cycle as a one-shot hit
    send_cmd(T_RUN, 8'd10, 1'b1, 1'b0, waits);
    monitor(3, en_c, ld_c, dn_c, bz_c);
    check("hitcmd_en_pre", 32'(en_c), 32'd3);
    check("hitcmd_at_limit", 32'(dp_count), 32'd10);
    check("hitcmd_hit_en", 32'(cnt_en), 32'd0);
    send_cmd(T_RUN, 8'd12, 1'b1, 1'b0, waits);
    check("hitcmd_state", 32'(state_o), 32'd2);
    check("hitcmd_done", 32'(done), 32'd1);
    check("hitcmd_count", 32'(dp_count), 32'd10);
    monitor(3, en_c, ld_c, dn_c, bz_c);
    check("hitcmd_en_post", 32'(en_c), 32'd2);
    check("hitcmd_done_cnt", 32'(dn_c), 32'd1);
    check("hitcmd_end_state", 32'(state_o), 32'd0);
    check("hitcmd_end_done", 32'(done), 32'd1);
    check("hitcmd_rest", 32'(dp_count), 32'd12);

    // LOAD during RUN stops the count
    send_cmd(T_RUN, 8'd50, 1'b1, 1'b1, waits);
    monitor(2, en_c, ld_c, dn_c, bz_c);
    check("ldrun_count", 32'(dp_count), 32'd14);
    send_cmd(T_LOAD, 8'd20, 1'b0, 1'b0, waits);
    check("ldrun_state", 32'(state_o), 32'd1);
    check("ldrun_val", 32'(cnt_load_val), 32'd20);
    @(negedge clk);
    check("ldrun_idle", 32'(state_o), 32'd0);
    check("ldrun_loaded", 32'(dp_count), 32'd20);

    // CLEAR loads zero via LOADING
    send_cmd(T_CLEAR, 8'd0, 1'b0, 1'b0, waits);
    check("clr_state", 32'(state_o), 32'd1);
    check("clr_load", 32'(cnt_load), 32'd1);
    check("clr_val", 32'(cnt_load_val), 32'd0);
    @(negedge clk);
    check("clr_idle", 32'(state_o), 32'd0);
    check("clr_count", 32'(dp_count), 32'd0);

    // Down from 0 wraps to 255 (the limit), reload 0, then async reset
    send_cmd(T_RUN, 8'd255, 1'b0, 1'b1, waits);
    @(negedge clk);
    check("modwrap_count", 32'(dp_count), 32'd255);
    check("modwrap_load", 32'(cnt_load), 32'd1);
    @(negedge clk);
    check("pre_rst_done", 32'(done), 32'd1);
    check("pre_rst_en", 32'(cnt_en), 32'd1);
    check("pre_rst_up", 32'(cnt_up), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_en", 32'(cnt_en), 32'd0);
    check("arst_load", 32'(cnt_load), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_up", 32'(cnt_up), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(state_o), 32'd0);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
